// File: rtl/frac_clk_gen_if.sv
// Configuration handshake bundle for frac_clk_gen: requested N/D/mode plus
// ready/error status back to the requester.
interface frac_clk_gen_if #(
  parameter int unsigned CNT_W = 8
) ();
  logic [CNT_W-1:0] cfg_num;
  logic [CNT_W-1:0] cfg_den;
  logic             cfg_mode;
  logic             cfg_valid;
  logic             cfg_ready;
  logic             cfg_err;

  modport master (
    output cfg_num, cfg_den, cfg_mode, cfg_valid,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_num, cfg_den, cfg_mode, cfg_valid,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/frac_clk_gen.sv
// Fractional clock divider: emits D output periods per N source cycles by
// alternating period lengths Q and Q+1 with an error accumulator.
module frac_clk_gen #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned DEF_NUM = 76,
  parameter int unsigned DEF_DEN = 10
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            en,
  frac_clk_gen_if.slave   cfg,
  output logic            tick,
  output logic            clk_out
);

  localparam logic [CNT_W-1:0] One  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DefQ = CNT_W'(DEF_NUM / DEF_DEN);
  localparam logic [CNT_W-1:0] DefR = CNT_W'(DEF_NUM % DEF_DEN);
  localparam logic [CNT_W-1:0] DefD = CNT_W'(DEF_DEN);

  logic [CNT_W-1:0] den_q, den_d, q_q, q_d, r_q, r_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] sh_den_q, sh_den_d, sh_q_q, sh_q_d, sh_r_q, sh_r_d;
  logic             sh_mode_q, sh_mode_d;
  logic             pend_q, pend_d;
  logic             run_q, run_d;
  logic [CNT_W-1:0] phase_q, phase_d, len_q, len_d, acc_q, acc_d;
  logic             tick_q, tick_d, clk_out_q, clk_out_d, err_q, err_d;

  logic             accept, legal, last, swap;
  logic [CNT_W-1:0] div_den, req_quot, req_rem, base;
  logic [CNT_W:0]   sum;

  always_comb begin
    den_d     = den_q;
    q_d       = q_q;
    r_d       = r_q;
    mode_d    = mode_q;
    sh_den_d  = sh_den_q;
    sh_q_d    = sh_q_q;
    sh_r_d    = sh_r_q;
    sh_mode_d = sh_mode_q;
    pend_d    = pend_q;
    run_d     = run_q;
    phase_d   = phase_q;
    len_d     = len_q;
    acc_d     = acc_q;
    err_d     = 1'b0;

    // Divider input is forced non-zero; a zero denominator is rejected anyway.
    div_den  = (cfg.cfg_den == '0) ? One : cfg.cfg_den;
    req_quot = cfg.cfg_num / div_den;
    req_rem  = cfg.cfg_num % div_den;
    legal    = (cfg.cfg_den != '0) && (cfg.cfg_num >= cfg.cfg_den) &&
               (!cfg.cfg_mode || ({1'b0, cfg.cfg_num} >= {cfg.cfg_den, 1'b0}));

    accept = cfg.cfg_valid && !pend_q;
    last   = run_q && (phase_q == len_q - One);
    swap   = pend_q && (!en || last);

    if (swap) begin
      den_d  = sh_den_q;
      q_d    = sh_q_q;
      r_d    = sh_r_q;
      mode_d = sh_mode_q;
      pend_d = 1'b0;
    end

    // Accept and swap are exclusive: accept needs pend_q low, swap needs it high.
    if (accept) begin
      if (legal) begin
        sh_den_d  = cfg.cfg_den;
        sh_q_d    = req_quot;
        sh_r_d    = req_rem;
        sh_mode_d = cfg.cfg_mode;
        pend_d    = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    base = (swap || !run_q) ? '0 : acc_q;
    sum  = {1'b0, base} + {1'b0, r_d};

    if (!en) begin
      run_d   = 1'b0;
      phase_d = '0;
      acc_d   = '0;
    end else if (!run_q || last) begin
      run_d   = 1'b1;
      phase_d = '0;
      if (sum >= {1'b0, den_d}) begin
        len_d = q_d + One;
        acc_d = CNT_W'(sum - {1'b0, den_d});
      end else begin
        len_d = q_d;
        acc_d = sum[CNT_W-1:0];
      end
    end else begin
      phase_d = phase_q + One;
    end

    tick_d    = run_d && (phase_d == len_d - One);
    clk_out_d = mode_d ? (run_d && (phase_d < (len_d >> 1))) : tick_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      den_q     <= DefD;
      q_q       <= DefQ;
      r_q       <= DefR;
      mode_q    <= 1'b0;
      sh_den_q  <= '0;
      sh_q_q    <= '0;
      sh_r_q    <= '0;
      sh_mode_q <= 1'b0;
      pend_q    <= 1'b0;
      run_q     <= 1'b0;
      phase_q   <= '0;
      len_q     <= One;
      acc_q     <= '0;
      tick_q    <= 1'b0;
      clk_out_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      den_q     <= den_d;
      q_q       <= q_d;
      r_q       <= r_d;
      mode_q    <= mode_d;
      sh_den_q  <= sh_den_d;
      sh_q_q    <= sh_q_d;
      sh_r_q    <= sh_r_d;
      sh_mode_q <= sh_mode_d;
      pend_q    <= pend_d;
      run_q     <= run_d;
      phase_q   <= phase_d;
      len_q     <= len_d;
      acc_q     <= acc_d;
      tick_q    <= tick_d;
      clk_out_q <= clk_out_d;
      err_q     <= err_d;
    end
  end

  assign cfg.cfg_ready = !pend_q;
  assign cfg.cfg_err   = err_q;
  assign tick          = tick_q;
  assign clk_out       = clk_out_q;

endmodule

// File: doc/frac_clk_gen.md
FRAC_CLK_GEN -- requirements
Module: frac_clk_gen

Interface
REQ-001 Parameter CNT_W, default 8: width of cfg_num, cfg_den, the phase counter and the accumulator.
REQ-002 Parameter DEF_NUM, default 76: source-clock cycles per DEF_DEN output periods, loaded at reset.
REQ-003 Parameter DEF_DEN, default 10: output periods per DEF_NUM source cycles, loaded at reset.
REQ-004 clk  input  1  source clock; all logic on rising edge.
REQ-005 rstn  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  generator enable.
REQ-007 cfg_num  input  CNT_W  requested numerator N (source cycles).
REQ-008 cfg_den  input  CNT_W  requested denominator D (output periods).
REQ-009 cfg_mode  input  1  0 = pulse output, 1 = level (near-50% duty) output.
REQ-010 cfg_valid  input  1  configuration request.
REQ-011 cfg_ready  output  1  configuration can be accepted.
REQ-012 cfg_err  output  1  one-cycle pulse: accepted request rejected as illegal.
REQ-013 tick  output  1  one-cycle pulse on the last source cycle of each output period.
REQ-014 clk_out  output  1  divided clock; equals tick in mode 0, level waveform in mode 1.

Function
REQ-015 The active configuration is (N, D, mode), with Q = N/D and R = N mod D, both computed from the active configuration and held in registers.
REQ-016 At each period start: acc_sum = acc + R; if acc_sum >= D, length L = Q+1 and acc <= acc_sum - D; otherwise L = Q and acc <= acc_sum.
- acc_sum is CNT_W+1 bits wide; no overflow is permitted.
REQ-017 Over any D consecutive periods starting with acc = 0, the period lengths sum to exactly N source cycles.
REQ-018 The phase counter counts 0..L-1; tick is registered and is high exactly in the cycle where phase == L-1.
REQ-019 In mode 1, clk_out is high for phase 0..floor(L/2)-1 and low otherwise; all edges are registered, with no glitches.
REQ-020 With en=0: phase = 0, acc = 0, tick = 0, clk_out = 0; the configuration is retained.
REQ-021 When en rises (sampled high at edge k), phase 0 is the cycle after edge k, so the first tick appears L cycles after en was sampled high.
REQ-022 If en falls mid-period, outputs go low on the next edge; the partial period produces no tick.
REQ-023 Handshake: a request is accepted when cfg_valid && cfg_ready on a rising edge; cfg_num, cfg_den and cfg_mode are captured into a shadow register.
REQ-024 cfg_ready = 0 while a shadow configuration is pending; otherwise cfg_ready = 1.
REQ-025 Legality: a request is illegal if D == 0, N < D, or (mode == 1 and N < 2*D).
- An illegal request is accepted and discarded; cfg_err pulses one cycle later.
- The active configuration and the pending state are unchanged.
REQ-026 The pending shadow becomes active at the first edge where phase == L-1 (period boundary) or en == 0; on that edge acc is cleared and cfg_ready returns to 1.
REQ-027 The active configuration never changes mid-period.
REQ-028 If a period boundary and an acceptance occur on the same edge, the accepted configuration applies at the following boundary, not the current one.
REQ-029 N == D in mode 0 gives tick high continuously; this is legal.
REQ-030 The block has no combinational path from any input to any output.

Reset
REQ-031 While rstn = 0, the block SHALL hold: tick = 0, clk_out = 0, cfg_err = 0, cfg_ready = 1, phase = 0, acc = 0, active configuration = (DEF_NUM, DEF_DEN, 0), no pending shadow.
REQ-032 Reset assertion mid-period or mid-pending SHALL abandon all state immediately; the first tick after release follows REQ-021.

Verification
REQ-033 Defaults, en=1 held → period lengths 7,8,7,8,8,7,8,7,8,8 repeating; 76 clk per 10 ticks.
REQ-034 Request (N=9, D=4, mode 1) accepted mid-period → current period completes unchanged; then lengths 2,2,2,3 repeating (Q=2, R=1, acc cleared); clk_out high 1 cycle per period.
REQ-035 Requests (D=0), (N=3, D=5), (N=5, D=3, mode 1) → cfg_err pulse for each; tick pattern unchanged.
REQ-036 Back-to-back cfg_valid → cfg_ready low after first acceptance until boundary; second request accepted only after cfg_ready returns high.
REQ-037 en dropped at phase 3 of an 8-cycle period, re-raised 5 cycles later → no tick during the gap; the sequence restarts with acc=0 (first length 7 at defaults).
REQ-038 rstn pulsed low while a shadow is pending → defaults active, pending discarded, cfg_ready = 1 during reset.
